// File: rtl/jtag_host_if.sv
// Command/response bus between a requester and the JTAG host.
// The master modport is the requester; the slave modport is the host.
interface jtag_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_reset;
    logic        cmd_ir;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;

    modport master (
        output cmd_valid, cmd_reset, cmd_ir, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_reset, cmd_ir, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/jtag_host.sv
// JTAG host: runs Test-Logic-Reset, IR and DR scans of up to 32 bits,
// driving a divided TCK and returning captured TDO bits LSB first.
module jtag_host #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic         sysclk,
    input  logic         sys_reset,
    jtag_host_if.slave   bus,
    output logic         tck,
    output logic         tms,
    output logic         tdi,
    input  logic         tdo
);
    localparam int unsigned HC_W   = 8;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam logic [HC_W-1:0] HC_MAX = HC_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {H_TLR, H_IDLE, H_HDR, H_SHIFT, H_POST, H_RSP} state_e;

    state_e              state_q, state_d;
    logic [HC_W-1:0]     hc_q, hc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic                ir_q, ir_d;
    logic                rstcmd_q, rstcmd_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    len_eff;
    logic                period_end;

    always_comb begin
        state_d     = state_q;
        hc_d        = hc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ir_d        = ir_q;
        rstcmd_d    = rstcmd_q;
        data_d      = data_q;
        cap_d       = cap_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        busy_d      = busy_q;
        len_eff     = (bus.cmd_len > 6'd32) ? 6'd32 : bus.cmd_len;
        period_end  = tck_q && (hc_q == HC_MAX);

        case (state_q)
            H_IDLE: begin
                if (bus.cmd_valid) begin
                    data_d  = bus.cmd_data;
                    ir_d    = bus.cmd_ir;
                    len_d   = len_eff;
                    cap_d   = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    hc_d    = '0;
                    tck_d   = 1'b0;
                    tdi_d   = 1'b0;
                    if (bus.cmd_reset) begin
                        state_d  = H_TLR;
                        rstcmd_d = 1'b1;
                        tms_d    = 1'b1;
                    end else if (len_eff == '0) begin
                        state_d     = H_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                    end else begin
                        state_d = H_HDR;
                        tms_d   = 1'b1;
                    end
                end
            end
            H_RSP: begin
                state_d = H_IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                // Every other state clocks TCK periods; tms/tdi move only at a period boundary.
                if (!period_end) begin
                    if (hc_q == HC_MAX) begin
                        tck_d = 1'b1;
                        hc_d  = '0;
                    end else begin
                        hc_d = hc_q + 8'd1;
                    end
                end else begin
                    tck_d = 1'b0;
                    hc_d  = '0;
                    cnt_d = cnt_q + 6'd1;
                    case (state_q)
                        H_TLR: begin
                            if (cnt_q == 6'd5) begin
                                cnt_d = '0;
                                tms_d = 1'b0;
                                if (rstcmd_q) begin
                                    state_d     = H_RSP;
                                    rstcmd_d    = 1'b0;
                                    rsp_valid_d = 1'b1;
                                    rsp_data_d  = '0;
                                end else begin
                                    state_d = H_IDLE;
                                    ready_d = 1'b1;
                                    busy_d  = 1'b0;
                                end
                            end else begin
                                tms_d = (cnt_q != 6'd4);
                            end
                        end
                        H_HDR: begin
                            if (cnt_q == (ir_q ? 6'd3 : 6'd2)) begin
                                state_d = H_SHIFT;
                                cnt_d   = '0;
                                tms_d   = (len_q == 6'd1);
                                tdi_d   = data_q[0];
                            end else begin
                                tms_d = ir_q && (cnt_q == 6'd0);
                            end
                        end
                        H_SHIFT: begin
                            // tdo is still stable here: the target only changes it on the falling edge.
                            cap_d[cnt_q[4:0]] = tdo;
                            if (cnt_q == len_q - 6'd1) begin
                                state_d = H_POST;
                                cnt_d   = '0;
                                tms_d   = 1'b1;
                                tdi_d   = 1'b0;
                            end else begin
                                tms_d = (cnt_q + 6'd2 == len_q);
                                tdi_d = data_q[5'(cnt_q + 6'd1)];
                            end
                        end
                        H_POST: begin
                            tms_d = 1'b0;
                            if (cnt_q == 6'd1) begin
                                state_d     = H_RSP;
                                cnt_d       = '0;
                                rsp_valid_d = 1'b1;
                                rsp_data_d  = cap_q;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q     <= H_TLR;
            hc_q        <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            ir_q        <= 1'b0;
            rstcmd_q    <= 1'b0;
            data_q      <= '0;
            cap_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            hc_q        <= hc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ir_q        <= ir_d;
            rstcmd_q    <= rstcmd_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign tck           = tck_q;
    assign tms           = tms_q;
    assign tdi           = tdi_q;
    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: a TAP target model answers scans, expected responses
// are queued at command issue and matched against each rsp_valid pulse.
module tb_jtag_host;
    localparam int unsigned CLK_DIV = 2;
    localparam int TP = 2 * CLK_DIV;
    localparam logic [31:0] IDCODE = 32'h1A6B_C0DF;
    localparam logic [3:0]  IR_IDCODE = 4'hE;

    logic sysclk = 1'b0;
    logic sys_reset;
    logic tck, tms, tdi, tdo;
    logic tdo_force = 1'b0;
    logic tap_tdo = 1'b0;

    jtag_host_if bus();

    jtag_host #(.CLK_DIV(CLK_DIV)) dut (
        .sysclk    (sysclk),
        .sys_reset (sys_reset),
        .bus       (bus),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo)
    );

    always #5 sysclk = ~sysclk;
    assign tdo = tdo_force ? 1'b1 : tap_tdo;

    // TAP target model
    typedef enum logic [3:0] {T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PSDR, T_EX2DR,
                              T_UPDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PSIR, T_EX2IR, T_UPIR} tap_e;
    tap_e        tst = T_TLR;
    logic [31:0] dr  = '0;
    logic [3:0]  irs = '0;
    logic [3:0]  ir  = IR_IDCODE;

    always @(posedge tck) begin
        case (tst)
            T_TLR:   ir  = IR_IDCODE;
            T_CAPDR: dr  = (ir == IR_IDCODE) ? IDCODE : 32'h0;
            T_SHDR:  dr  = {tdi, dr[31:1]};
            T_CAPIR: irs = 4'b0001;
            T_SHIR:  irs = {tdi, irs[3:1]};
            T_UPIR:  ir  = irs;
            default: ;
        endcase
        case (tst)
            T_TLR:   tst = tms ? T_TLR   : T_RTI;
            T_RTI:   tst = tms ? T_SELDR : T_RTI;
            T_SELDR: tst = tms ? T_SELIR : T_CAPDR;
            T_CAPDR: tst = tms ? T_EX1DR : T_SHDR;
            T_SHDR:  tst = tms ? T_EX1DR : T_SHDR;
            T_EX1DR: tst = tms ? T_UPDR  : T_PSDR;
            T_PSDR:  tst = tms ? T_EX2DR : T_PSDR;
            T_EX2DR: tst = tms ? T_UPDR  : T_SHDR;
            T_UPDR:  tst = tms ? T_SELDR : T_RTI;
            T_SELIR: tst = tms ? T_TLR   : T_CAPIR;
            T_CAPIR: tst = tms ? T_EX1IR : T_SHIR;
            T_SHIR:  tst = tms ? T_EX1IR : T_SHIR;
            T_EX1IR: tst = tms ? T_UPIR  : T_PSIR;
            T_PSIR:  tst = tms ? T_EX2IR : T_PSIR;
            T_EX2IR: tst = tms ? T_UPIR  : T_SHIR;
            default: tst = tms ? T_SELDR : T_RTI;
        endcase
    end

    always @(negedge tck) begin
        if (tst == T_SHDR)      tap_tdo = dr[0];
        else if (tst == T_SHIR) tap_tdo = irs[0];
    end

    // Scoreboard and monitors
    typedef struct { logic [31:0] data; int lat; } exp_t;
    typedef struct { logic [31:0] data; int cyc; } obs_t;
    exp_t exp_q[$];
    obs_t obs_q[$];
    int   hs_cyc[$];
    logic tms_log[$];
    logic tdi_log[$];
    obs_t mon_o;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always @(posedge sysclk) begin
        if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) hs_cyc.push_back(cyc + 1);
        cyc <= cyc + 1;
    end

    always @(negedge sysclk) begin
        if (bus.rsp_valid === 1'b1) begin
            mon_o.data = bus.rsp_data;
            mon_o.cyc  = cyc;
            obs_q.push_back(mon_o);
        end
    end

    always @(posedge tck) begin
        tms_log.push_back(tms);
        tdi_log.push_back(tdi);
    end

    function automatic logic [63:0] pack_q(input logic q[$]);
        logic [63:0] v = '0;
        for (int i = 0; i < q.size() && i < 64; i++) v[i] = q[i];
        return v;
    endfunction

    task automatic clear_logs();
        tms_log.delete();
        tdi_log.delete();
        obs_q.delete();
        hs_cyc.delete();
    endtask

    task automatic send(input logic rst_c, input logic ir_c, input logic [5:0] len,
                        input logic [31:0] data, input logic [31:0] exp_data, input int periods);
        exp_t e;
        int   n = 0;
        @(negedge sysclk);
        bus.cmd_reset = rst_c;
        bus.cmd_ir    = ir_c;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        e.data = exp_data;
        e.lat  = periods * TP;
        exp_q.push_back(e);
        while (bus.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        @(negedge sysclk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic check_rsp(input string name, input int budget);
        obs_t o;
        exp_t e;
        int   h;
        int   n = 0;
        while (obs_q.size() == 0 && n < budget) begin
            @(negedge sysclk);
            n++;
        end
        compared++;
        if (obs_q.size() == 0 || exp_q.size() == 0 || hs_cyc.size() == 0) begin
            mismatched++;
            $display("FAIL %s rsp: no response within %0d cycles", name, budget);
            exp_q.delete();
            return;
        end
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        h = hs_cyc.pop_front();
        if (o.data !== e.data) begin
            mismatched++;
            $display("FAIL %s data: got %h want %h", name, o.data, e.data);
        end
        compared++;
        if (o.cyc - h !== e.lat) begin
            mismatched++;
            $display("FAIL %s latency: got %0d want %0d", name, o.cyc - h, e.lat);
        end
    endtask

    task automatic test_reset();
        sys_reset = 1'b1;
        repeat (3) @(negedge sysclk);
        compared++;
        if ({tck, tms, tdi, bus.cmd_ready, bus.rsp_valid, bus.busy} !== 6'b010001) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b want 010001",
                     {tck, tms, tdi, bus.cmd_ready, bus.rsp_valid, bus.busy});
        end
        compared++;
        if (bus.rsp_data !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data);
        end
        clear_logs();
        sys_reset = 1'b0;
        repeat (23) @(negedge sysclk);
        compared++;
        if (bus.cmd_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL tlr_ready_early: got %b want 0", bus.cmd_ready);
        end
        @(negedge sysclk);
        compared++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL tlr_ready: got ready=%b busy=%b want 1/0", bus.cmd_ready, bus.busy);
        end
        compared++;
        if (tms_log.size() != 6 || pack_q(tms_log) !== 64'h1F) begin
            mismatched++;
            $display("FAIL tlr_tms: got %0d pulses %h want 6 pulses 1f", tms_log.size(), pack_q(tms_log));
        end
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("FAIL tlr_no_rsp: got %0d responses want 0", obs_q.size());
        end
    endtask

    task automatic test_dr_idcode();
        clear_logs();
        tdo_force = 1'b0;
        send(1'b0, 1'b0, 6'd32, 32'h0, IDCODE, 37);
        check_rsp("dr_idcode", 400);
        compared++;
        if (tms_log.size() != 37 || pack_q(tms_log) !== 64'h0000_000C_0000_0001) begin
            mismatched++;
            $display("FAIL dr_idcode_tms: got %0d pulses %h want 37 pulses c00000001",
                     tms_log.size(), pack_q(tms_log));
        end
    endtask

    task automatic test_ir_scan();
        clear_logs();
        send(1'b0, 1'b1, 6'd4, 32'h2, 32'h1, 10);
        check_rsp("ir_scan", 200);
        compared++;
        if (tms_log.size() != 10 || pack_q(tms_log) !== 64'h183) begin
            mismatched++;
            $display("FAIL ir_tms: got %0d pulses %h want 10 pulses 183", tms_log.size(), pack_q(tms_log));
        end
        compared++;
        if (pack_q(tdi_log) !== 64'h20) begin
            mismatched++;
            $display("FAIL ir_tdi: got %h want 20", pack_q(tdi_log));
        end
    endtask

    task automatic test_len_edges();
        logic [63:0] t;
        tdo_force = 1'b1;
        clear_logs();
        send(1'b0, 1'b0, 6'd5, 32'h0, 32'h0000_001F, 10);
        check_rsp("len5", 200);
        clear_logs();
        send(1'b0, 1'b0, 6'd0, 32'hFFFF_FFFF, 32'h0, 0);
        check_rsp("len0", 50);
        repeat (4) @(negedge sysclk);
        compared++;
        if (tms_log.size() != 0) begin
            mismatched++;
            $display("FAIL len0_tck: got %0d pulses want 0", tms_log.size());
        end
        clear_logs();
        send(1'b0, 1'b0, 6'd40, 32'hA5A5_3C96, 32'hFFFF_FFFF, 37);
        check_rsp("len40", 400);
        t = pack_q(tdi_log) >> 3;
        compared++;
        if (tms_log.size() != 37 || t[31:0] !== 32'hA5A5_3C96) begin
            mismatched++;
            $display("FAIL len40_shift: got %0d pulses tdi %h want 37 pulses tdi a5a53c96",
                     tms_log.size(), t[31:0]);
        end
        tdo_force = 1'b0;
    endtask

    task automatic test_reset_cmd();
        clear_logs();
        send(1'b1, 1'b1, 6'd8, 32'hFFFF_FFFF, 32'h0, 6);
        check_rsp("reset_cmd", 100);
        compared++;
        if (tms_log.size() != 6 || pack_q(tms_log) !== 64'h1F) begin
            mismatched++;
            $display("FAIL reset_cmd_tms: got %0d pulses %h want 6 pulses 1f", tms_log.size(), pack_q(tms_log));
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   h1 = 0;
        int   n = 0;
        tdo_force = 1'b1;
        clear_logs();
        e.data = 32'h0000_00FF;
        e.lat  = 13 * TP;
        exp_q.push_back(e);
        exp_q.push_back(e);
        @(negedge sysclk);
        bus.cmd_reset = 1'b0;
        bus.cmd_ir    = 1'b0;
        bus.cmd_len   = 6'd8;
        bus.cmd_data  = 32'h0;
        bus.cmd_valid = 1'b1;
        while (hs_cyc.size() == 0 && n < 100) begin
            @(negedge sysclk);
            n++;
        end
        if (hs_cyc.size() != 0) h1 = hs_cyc[0];
        check_rsp("b2b_first", 200);
        compared++;
        if (hs_cyc.size() != 0) begin
            mismatched++;
            $display("FAIL b2b_busy_accept: got %0d extra handshakes want 0", hs_cyc.size());
        end
        n = 0;
        while (hs_cyc.size() == 0 && n < 20) begin
            @(negedge sysclk);
            n++;
        end
        bus.cmd_valid = 1'b0;
        compared++;
        if (hs_cyc.size() != 1 || hs_cyc[0] - h1 != 13 * TP + 2) begin
            mismatched++;
            $display("FAIL b2b_second_accept: got %0d handshakes gap %0d want 1 gap %0d",
                     hs_cyc.size(), (hs_cyc.size() != 0) ? hs_cyc[0] - h1 : -1, 13 * TP + 2);
        end
        check_rsp("b2b_second", 200);
        tdo_force = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_logs();
        @(negedge sysclk);
        bus.cmd_reset = 1'b0;
        bus.cmd_ir    = 1'b0;
        bus.cmd_len   = 6'd32;
        bus.cmd_data  = 32'h0;
        bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge sysclk);
            n++;
        end
        @(negedge sysclk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (tms_log.size() < 14 && n < 200) begin
            @(negedge sysclk);
            n++;
        end
        #1 sys_reset = 1'b1;
        #1;
        compared++;
        if (tck !== 1'b0 || tms !== 1'b1 || bus.busy !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_reset_async: got tck=%b tms=%b busy=%b want 0/1/1", tck, tms, bus.busy);
        end
        repeat (2) @(negedge sysclk);
        clear_logs();
        sys_reset = 1'b0;
        repeat (30) @(negedge sysclk);
        compared++;
        if (obs_q.size() != 0) begin
            mismatched++;
            $display("FAIL mid_reset_no_rsp: got %0d responses want 0", obs_q.size());
        end
        compared++;
        if (tms_log.size() != 6 || pack_q(tms_log) !== 64'h1F || bus.cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_reset_tlr: got %0d pulses %h ready=%b want 6 pulses 1f ready=1",
                     tms_log.size(), pack_q(tms_log), bus.cmd_ready);
        end
    endtask

    initial begin
        sys_reset     = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_reset = 1'b0;
        bus.cmd_ir    = 1'b0;
        bus.cmd_len   = 6'd0;
        bus.cmd_data  = 32'h0;
        test_reset();
        test_dr_idcode();
        test_ir_scan();
        test_len_edges();
        test_reset_cmd();
        test_back_to_back();
        test_reset_mid();
        test_dr_idcode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
